dmem_responder: RTL and testbench

- Data-memory responder for the 16-bit processor's load/store port. The processor core is the initiator; this block accepts one request at a time, applies a configurable number of wait states, performs the read or write, and returns a held response.
- Sits between the core's data-side request lines and the word-addressed data RAM. Backs `sw` stores and `lw` loads.

---
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the 16-bit core's load/store port: one request at a time,
// WAIT_CYCLES wait states, held response. Optional parity storage via DMEM_PARITY_EN.
module dmem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              enter_resp;
    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;
    logic              par_err;

    assign req_ready  = (state_q == IDLE) && reset;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With zero wait states the access happens on the accept edge, so it uses the live request.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign in_range = (32'(acc_addr) < DEPTH);
    assign rd_word  = in_range ? mem[acc_addr] : '0;

`ifdef DMEM_PARITY_EN
    logic             par_mem [DEPTH];
    logic [DEPTH-1:0] parity_flip;

    assign parity_flip = '0;
    assign par_err     = in_range && ((^rd_word) != (par_mem[acc_addr] ^ parity_flip[acc_addr]));

    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_mem[acc_addr] <= ^acc_wdata;
        end
    end
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            rdata_d = acc_we ? '0 : rd_word;
            err_d   = !in_range || (!acc_we && par_err);
        end
    end

    // A reset on the would-be RESP edge abandons the store.
    assign mem_we = enter_resp && acc_we && in_range && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT 1/DEPTH 200, WAIT 0, WAIT 3).
// Parity fault injection is exercised only when DMEM_PARITY_EN is defined.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        reqValid  [3];
    logic        reqReady  [3];
    logic        reqWe     [3];
    logic [7:0]  reqAddr   [3];
    logic [15:0] reqWdata  [3];
    logic        respValid [3];
    logic        respReady [3];
    logic [15:0] respRdata [3];
    logic        respErr   [3];

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0])
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1])
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_we(reqWe[2]),
        .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]),
        .resp_valid(respValid[2]), .resp_ready(respReady[2]),
        .resp_rdata(respRdata[2]), .resp_err(respErr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One full transaction on instance idx, entered and left at a falling edge.
    task automatic applyStimulus(input int idx, input logic we, input logic [7:0] addr,
                                 input logic [15:0] wdata, input int hold,
                                 input logic [15:0] expRdata, input logic expErr,
                                 input int expLat, input string tag);
        int lat;
        reqWe[idx]     = we;
        reqAddr[idx]   = addr;
        reqWdata[idx]  = wdata;
        reqValid[idx]  = 1'b1;
        respReady[idx] = 1'b0;
        checkOutput({tag, "_reqready"}, 32'(reqReady[idx]), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            reqValid[idx] = 1'b0;
        end while (!respValid[idx] && lat < 20);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_rdata"}, 32'(respRdata[idx]), 32'(expRdata));
        checkOutput({tag, "_err"}, 32'(respErr[idx]), 32'(expErr));
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                reqWe[idx]    = 1'b1;
                reqWdata[idx] = 16'hFFFF;
                reqValid[idx] = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, 32'(respValid[idx]), 32'd1);
            checkOutput({tag, "_hold_rdata"}, 32'(respRdata[idx]), 32'(expRdata));
            checkOutput({tag, "_hold_reqready"}, 32'(reqReady[idx]), 32'd0);
        end
        reqValid[idx]  = 1'b0;
        respReady[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_valid"}, 32'(respValid[idx]), 32'd0);
        checkOutput({tag, "_done_reqready"}, 32'(reqReady[idx]), 32'd1);
        respReady[idx] = 1'b0;
    endtask

    // Requests held continuously with resp_ready high; accepts must be expGap cycles apart.
    task automatic checkSpacing(input int idx, input int expGap, input string tag);
        int acc[$];
        reqWe[idx]     = 1'b0;
        reqAddr[idx]   = 8'd0;
        reqValid[idx]  = 1'b1;
        respReady[idx] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (reqReady[idx]) acc.push_back(c);
            @(posedge clk);
            @(negedge clk);
        end
        reqValid[idx] = 1'b0;
        repeat (8) @(negedge clk);
        respReady[idx] = 1'b0;
        checkOutput({tag, "_count_ge3"}, 32'(acc.size() >= 3), 32'd1);
        if (acc.size() >= 3) begin
            checkOutput({tag, "_gap1"}, 32'(acc[1] - acc[0]), 32'(expGap));
            checkOutput({tag, "_gap2"}, 32'(acc[2] - acc[1]), 32'(expGap));
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            reqValid[i]  = 1'b1;
            reqWe[i]     = 1'b1;
            reqAddr[i]   = 8'd3;
            reqWdata[i]  = 16'hBEEF;
            respReady[i] = 1'b0;
        end
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("rst%0d_reqready", i), 32'(reqReady[i]), 32'd0);
                checkOutput($sformatf("rst%0d_valid", i), 32'(respValid[i]), 32'd0);
                checkOutput($sformatf("rst%0d_rdata", i), 32'(respRdata[i]), 32'd0);
                checkOutput($sformatf("rst%0d_err", i), 32'(respErr[i]), 32'd0);
            end
        end
        for (int i = 0; i < 3; i++) reqValid[i] = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(0, 1'b1, 8'd5, 16'h00A7, 0, 16'h0000, 1'b0, 2, "st5");
        applyStimulus(0, 1'b0, 8'd5, 16'h0000, 0, 16'h00A7, 1'b0, 2, "ld5");
        applyStimulus(0, 1'b0, 8'd5, 16'h0000, 3, 16'h00A7, 1'b0, 2, "bp_ld5");
        applyStimulus(0, 1'b0, 8'd5, 16'h0000, 0, 16'h00A7, 1'b0, 2, "bp_reld5");

        applyStimulus(0, 1'b1, 8'd199, 16'h5A5A, 0, 16'h0000, 1'b0, 2, "st199");
        applyStimulus(0, 1'b1, 8'd210, 16'h1234, 0, 16'h0000, 1'b1, 2, "st210");
        applyStimulus(0, 1'b0, 8'd210, 16'h0000, 0, 16'h0000, 1'b1, 2, "ld210");
        applyStimulus(0, 1'b0, 8'd199, 16'h0000, 0, 16'h5A5A, 1'b0, 2, "ld199");

        // Reset lands on the edge that would enter RESP: the store must be abandoned.
        applyStimulus(0, 1'b1, 8'd3, 16'h1111, 0, 16'h0000, 1'b0, 2, "st3");
        reqWe[0]    = 1'b1;
        reqAddr[0]  = 8'd3;
        reqWdata[0] = 16'hBEEF;
        reqValid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_reqready", 32'(reqReady[0]), 32'd0);
        checkOutput("midrst_valid", 32'(respValid[0]), 32'd0);
        reqValid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'd3, 16'h0000, 0, 16'h1111, 1'b0, 2, "ld3_after_rst");

        applyStimulus(1, 1'b1, 8'd40, 16'hC3C3, 0, 16'h0000, 1'b0, 1, "w0_st40");
        applyStimulus(1, 1'b0, 8'd40, 16'h0000, 0, 16'hC3C3, 1'b0, 1, "w0_ld40");
        applyStimulus(2, 1'b1, 8'd77, 16'h8001, 0, 16'h0000, 1'b0, 4, "w3_st77");
        applyStimulus(2, 1'b0, 8'd77, 16'h0000, 0, 16'h8001, 1'b0, 4, "w3_ld77");

        checkSpacing(1, 2, "w0_spacing");
        checkSpacing(2, 5, "w3_spacing");

`ifdef DMEM_PARITY_EN
        applyStimulus(1, 1'b1, 8'd9, 16'h0F0F, 0, 16'h0000, 1'b0, 1, "par_st9");
        applyStimulus(1, 1'b0, 8'd9, 16'h0000, 0, 16'h0F0F, 1'b0, 1, "par_ld9_clean");
        force dut1.parity_flip[9] = 1'b1;
        applyStimulus(1, 1'b0, 8'd9, 16'h0000, 0, 16'h0F0F, 1'b1, 1, "par_ld9_flip");
        release dut1.parity_flip[9];
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
